// File: rtl/tge_pkg.sv
// rtl/tge_pkg.sv - shared types, LFSR taps and board index helpers for the 2048 engine
package tge_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SPAWN,
        ST_IDLE,
        ST_SHIFT,
        ST_DIFF,
        ST_CHECK,
        ST_OVER
    } state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int cell_idx(input int r, input int c, input int grid);
        return r * grid + c;
    endfunction

    // Cell j of line k, where j=0 is the wall the tiles slide toward
    function automatic int line_cell(input dir_e d, input int k, input int j, input int grid);
        case (d)
            DIR_UP:   return cell_idx(j, k, grid);
            DIR_DOWN: return cell_idx(grid - 1 - j, k, grid);
            DIR_LEFT: return cell_idx(k, j, grid);
            default:  return cell_idx(k, grid - 1 - j, grid);
        endcase
    endfunction

endpackage

// File: rtl/tge_if.sv
// rtl/tge_if.sv - move request handshake between direction source and board engine
interface tge_if;
    import tge_pkg::*;

    logic dir_valid;
    dir_e dir;
    logic dir_ready;
    logic undo;

    modport master (output dir_valid, output dir, output undo, input dir_ready);
    modport slave  (input dir_valid, input dir, input undo, output dir_ready);

endinterface

// File: rtl/tge_line_merge.sv
// rtl/tge_line_merge.sv - combinational compress/merge of one GRID-cell line toward index 0
module tge_line_merge #(
    parameter int GRID    = 4,
    parameter int VAL_W   = 4,
    parameter int DELTA_W = 19
) (
    input  logic [GRID*VAL_W-1:0] line_i,
    output logic [GRID*VAL_W-1:0] line_o,
    output logic [DELTA_W-1:0]    delta_o
);

    localparam logic [VAL_W-1:0] MAX_E = '1;

    // One spare trailing slot so the pair lookahead never leaves the array
    logic [VAL_W-1:0] packed_e [GRID+1];

    always_comb begin
        int   n;
        int   w;
        logic skip;
        logic [VAL_W-1:0] cur;
        for (int i = 0; i <= GRID; i++) packed_e[i] = '0;
        line_o  = '0;
        delta_o = '0;
        n       = 0;
        w       = 0;
        skip    = 1'b0;
        cur     = '0;

        for (int i = 0; i < GRID; i++) begin
            cur = line_i[i*VAL_W +: VAL_W];
            if (cur != '0) begin
                packed_e[n] = cur;
                n = n + 1;
            end
        end

        for (int i = 0; i < GRID; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (packed_e[i] != '0) begin
                if (packed_e[i] == packed_e[i+1] && packed_e[i] != MAX_E) begin
                    line_o[w*VAL_W +: VAL_W] = packed_e[i] + VAL_W'(1);
                    delta_o = delta_o + (DELTA_W'(1) << (packed_e[i] + VAL_W'(1)));
                    skip = 1'b1;
                end else begin
                    line_o[w*VAL_W +: VAL_W] = packed_e[i];
                end
                w = w + 1;
            end
        end
    end

endmodule

// File: rtl/tile_game_engine.sv
// rtl/tile_game_engine.sv - sequential 2048 board engine; TGE_UNDO_EN adds one-level undo
module tile_game_engine
    import tge_pkg::*;
#(
    parameter int          GRID    = 4,
    parameter int          VAL_W   = 4,
    parameter int          SCORE_W = 16,
    parameter int          WIN_EXP = 11,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tge_if.slave                        mv,
    output logic [GRID*GRID*VAL_W-1:0]  tiles,
    output logic [SCORE_W-1:0]          score,
    output logic                        moved,
    output logic                        win,
    output logic                        game_over
);

    localparam int NCELLS  = GRID * GRID;
    localparam int BOARD_W = NCELLS * VAL_W;
    localparam int IDX_W   = $clog2(NCELLS);
    localparam int K_W     = $clog2(GRID);
    localparam int DELTA_W = (1 << VAL_W) + 3;
    localparam int SUM_W   = ((SCORE_W > DELTA_W) ? SCORE_W : DELTA_W) + 1;

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [BOARD_W-1:0] tiles_q, tiles_d;
    logic [BOARD_W-1:0] snap_tiles_q, snap_tiles_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               moved_q, moved_d;
    logic               win_q, win_d;
    logic               over_q, over_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [IDX_W-1:0]   spawn_idx_q, spawn_idx_d;
    logic [IDX_W-1:0]   spawn_cnt_q, spawn_cnt_d;
    logic               init_left_q, init_left_d;

`ifdef TGE_UNDO_EN
    logic [SCORE_W-1:0] snap_score_q, snap_score_d;
    logic [BOARD_W-1:0] undo_tiles_q, undo_tiles_d;
    logic [SCORE_W-1:0] undo_score_q, undo_score_d;
    logic               undo_valid_q, undo_valid_d;
`else
    logic               unused_undo;
    assign unused_undo = mv.undo;
`endif

    logic [GRID*VAL_W-1:0] line_in, line_out;
    logic [DELTA_W-1:0]    delta;
    logic [SUM_W-1:0]      score_sum;
    logic [SCORE_W-1:0]    score_sat;
    logic [IDX_W-1:0]      seed_idx;
    logic [VAL_W-1:0]      spawn_cell;
    logic                  spawn_done;
    logic                  any_empty, has_pair, any_win;
    logic                  dir_ready;

    tge_line_merge #(.GRID(GRID), .VAL_W(VAL_W), .DELTA_W(DELTA_W)) u_merge (
        .line_i  (line_in),
        .line_o  (line_out),
        .delta_o (delta)
    );

    always_comb begin
        line_in = '0;
        for (int j = 0; j < GRID; j++)
            line_in[j*VAL_W +: VAL_W] = tiles_q[line_cell(dir_q, int'(k_q), j, GRID)*VAL_W +: VAL_W];
    end

    assign score_sum  = SUM_W'(score_q) + SUM_W'(delta);
    assign score_sat  = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];
    assign seed_idx   = IDX_W'(lfsr_q % 16'(NCELLS));
    assign spawn_cell = tiles_q[spawn_idx_q*VAL_W +: VAL_W];

    // Neighbour indices use modulo so every select stays in range; the guard discards the wrap
    always_comb begin
        logic [VAL_W-1:0] cur;
        any_empty = 1'b0;
        has_pair  = 1'b0;
        any_win   = 1'b0;
        cur       = '0;
        for (int r = 0; r < GRID; r++) begin
            for (int c = 0; c < GRID; c++) begin
                cur = tiles_q[cell_idx(r, c, GRID)*VAL_W +: VAL_W];
                if (cur == '0) any_empty = 1'b1;
                if (int'(cur) >= WIN_EXP) any_win = 1'b1;
                if (c < GRID - 1 && cur == tiles_q[cell_idx(r, (c + 1) % GRID, GRID)*VAL_W +: VAL_W])
                    has_pair = 1'b1;
                if (r < GRID - 1 && cur == tiles_q[cell_idx((r + 1) % GRID, c, GRID)*VAL_W +: VAL_W])
                    has_pair = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        k_d          = k_q;
        tiles_d      = tiles_q;
        snap_tiles_d = snap_tiles_q;
        score_d      = score_q;
        moved_d      = 1'b0;
        win_d        = win_q;
        over_d       = over_q;
        lfsr_d       = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        spawn_idx_d  = spawn_idx_q;
        spawn_cnt_d  = spawn_cnt_q;
        init_left_d  = init_left_q;
        spawn_done   = 1'b0;
        dir_ready    = 1'b0;
`ifdef TGE_UNDO_EN
        snap_score_d = snap_score_q;
        undo_tiles_d = undo_tiles_q;
        undo_score_d = undo_score_q;
        undo_valid_d = undo_valid_q;
`endif

        case (state_q)
            ST_INIT: begin
                init_left_d = 1'b1;
                spawn_idx_d = seed_idx;
                spawn_cnt_d = '0;
                state_d     = ST_SPAWN;
            end

            ST_SPAWN: begin
                if (spawn_cell == '0) begin
                    tiles_d[spawn_idx_q*VAL_W +: VAL_W] = (lfsr_q[2:0] == 3'd0) ? VAL_W'(2) : VAL_W'(1);
                    spawn_done = 1'b1;
                end else if (spawn_cnt_q == IDX_W'(NCELLS - 1)) begin
                    spawn_done = 1'b1;
                end else begin
                    spawn_idx_d = (spawn_idx_q == IDX_W'(NCELLS - 1)) ? '0 : spawn_idx_q + 1'b1;
                    spawn_cnt_d = spawn_cnt_q + 1'b1;
                end
                if (spawn_done) begin
                    if (init_left_q) begin
                        init_left_d = 1'b0;
                        spawn_idx_d = seed_idx;
                        spawn_cnt_d = '0;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_IDLE: begin
                dir_ready = 1'b1;
`ifdef TGE_UNDO_EN
                if (mv.undo) begin
                    if (undo_valid_q) begin
                        tiles_d      = undo_tiles_q;
                        score_d      = undo_score_q;
                        undo_valid_d = 1'b0;
                    end
                end else
`endif
                if (mv.dir_valid) begin
                    dir_d        = mv.dir;
                    k_d          = '0;
                    snap_tiles_d = tiles_q;
`ifdef TGE_UNDO_EN
                    snap_score_d = score_q;
`endif
                    state_d      = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                for (int j = 0; j < GRID; j++)
                    tiles_d[line_cell(dir_q, int'(k_q), j, GRID)*VAL_W +: VAL_W] = line_out[j*VAL_W +: VAL_W];
                score_d = score_sat;
                k_d     = k_q + 1'b1;
                if (k_q == K_W'(GRID - 1)) state_d = ST_DIFF;
            end

            ST_DIFF: begin
                if (tiles_q != snap_tiles_q) begin
                    moved_d     = 1'b1;
                    spawn_idx_d = seed_idx;
                    spawn_cnt_d = '0;
                    state_d     = ST_SPAWN;
`ifdef TGE_UNDO_EN
                    undo_tiles_d = snap_tiles_q;
                    undo_score_d = snap_score_q;
                    undo_valid_d = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CHECK: begin
                if (any_win) win_d = 1'b1;
                if (!any_empty && !has_pair) begin
                    over_d  = 1'b1;
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_OVER: ;

            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            dir_q        <= DIR_UP;
            k_q          <= '0;
            tiles_q      <= '0;
            snap_tiles_q <= '0;
            score_q      <= '0;
            moved_q      <= 1'b0;
            win_q        <= 1'b0;
            over_q       <= 1'b0;
            lfsr_q       <= SEED;
            spawn_idx_q  <= '0;
            spawn_cnt_q  <= '0;
            init_left_q  <= 1'b0;
`ifdef TGE_UNDO_EN
            snap_score_q <= '0;
            undo_tiles_q <= '0;
            undo_score_q <= '0;
            undo_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            k_q          <= k_d;
            tiles_q      <= tiles_d;
            snap_tiles_q <= snap_tiles_d;
            score_q      <= score_d;
            moved_q      <= moved_d;
            win_q        <= win_d;
            over_q       <= over_d;
            lfsr_q       <= lfsr_d;
            spawn_idx_q  <= spawn_idx_d;
            spawn_cnt_q  <= spawn_cnt_d;
            init_left_q  <= init_left_d;
`ifdef TGE_UNDO_EN
            snap_score_q <= snap_score_d;
            undo_tiles_q <= undo_tiles_d;
            undo_score_q <= undo_score_d;
            undo_valid_q <= undo_valid_d;
`endif
        end
    end

    assign mv.dir_ready = dir_ready;
    assign tiles        = tiles_q;
    assign score        = score_q;
    assign moved        = moved_q;
    assign win          = win_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_tile_game_engine.sv
// tb/tb_tile_game_engine.sv - directed self-checking bench for tile_game_engine
module tb_tile_game_engine;
    import tge_pkg::*;

    localparam int GRID    = 4;
    localparam int VAL_W   = 4;
    localparam int SCORE_W = 16;
    localparam int BW      = GRID * GRID * VAL_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    tge_if mv ();
    logic [BW-1:0]      tiles;
    logic [SCORE_W-1:0] score;
    logic               moved, win, game_over;

    int checks = 0;
    int failures = 0;

    logic [BW-1:0]      force_board;
    logic [SCORE_W-1:0] force_score;

    tile_game_engine #(
        .GRID(GRID), .VAL_W(VAL_W), .SCORE_W(SCORE_W), .WIN_EXP(11), .SEED(16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mv        (mv),
        .tiles     (tiles),
        .score     (score),
        .moved     (moved),
        .win       (win),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int count_nonzero(input logic [BW-1:0] b);
        int n = 0;
        for (int i = 0; i < GRID * GRID; i++) if (b[i*VAL_W +: VAL_W] != '0) n++;
        return n;
    endfunction

    function automatic bit spawn_vals_ok(input logic [BW-1:0] b);
        bit ok = 1'b1;
        for (int i = 0; i < GRID * GRID; i++)
            if (b[i*VAL_W +: VAL_W] > 4'd2) ok = 1'b0;
        return ok;
    endfunction

    // Overwrite the live board/score while the engine sits in IDLE
    task automatic load_board(input logic [BW-1:0] b, input logic [SCORE_W-1:0] s);
        force_board = b;
        force_score = s;
        force dut.tiles_q = force_board;
        force dut.score_q = force_score;
        @(negedge clk);
        @(negedge clk);
        release dut.tiles_q;
        release dut.score_q;
        @(negedge clk);
    endtask

    task automatic do_move(input dir_e d, output logic [BW-1:0] pre, output int mcnt, output bit ok);
        pre  = tiles;
        mcnt = 0;
        ok   = 1'b0;
        mv.dir       = d;
        mv.dir_valid = 1'b1;
        @(negedge clk);
        mv.dir_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (moved) begin
                if (mcnt == 0) pre = tiles;
                mcnt++;
            end
            if (mv.dir_ready || game_over) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * GRID * GRID + 3; i++) begin
            @(negedge clk);
            if (mv.dir_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        rst_n        = 1'b0;
        mv.dir_valid = 1'b0;
        mv.undo      = 1'b0;
        mv.dir       = DIR_UP;
        repeat (3) @(negedge clk);
        checks++; if (tiles !== '0) begin failures++; $display("FAIL reset_tiles got=%h exp=0", tiles); end
        checks++; if (score !== '0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        checks++; if (mv.dir_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", mv.dir_ready); end
        checks++; if ({moved, win, game_over} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {moved, win, game_over}); end
        rst_n = 1'b1;
        wait_ready(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL init_ready_timeout got=%b exp=1", ok); end
        checks++; if (count_nonzero(tiles) != 2) begin failures++; $display("FAIL init_tile_count got=%0d exp=2", count_nonzero(tiles)); end
        checks++; if (!spawn_vals_ok(tiles)) begin failures++; $display("FAIL init_tile_vals got=%h exp=cells_in_1_2", tiles); end
        checks++; if (score !== '0) begin failures++; $display("FAIL init_score got=%0d exp=0", score); end
    endtask

    task automatic test_merge_row;
        logic [BW-1:0] pre;
        int mcnt;
        bit ok;
        load_board(64'h0000_0000_0000_1111, 16'd0);
        do_move(DIR_LEFT, pre, mcnt, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL merge_done got=%b exp=1", ok); end
        checks++; if (pre !== 64'h0000_0000_0000_0022) begin failures++; $display("FAIL merge_board got=%h exp=%h", pre, 64'h0000_0000_0000_0022); end
        checks++; if (score !== 16'd8) begin failures++; $display("FAIL merge_score got=%0d exp=8", score); end
        checks++; if (mcnt != 1) begin failures++; $display("FAIL merge_moved_pulses got=%0d exp=1", mcnt); end
        checks++; if (count_nonzero(tiles) != 3) begin failures++; $display("FAIL merge_spawned got=%0d exp=3", count_nonzero(tiles)); end
    endtask

    task automatic test_no_double_merge;
        logic [BW-1:0] pre;
        int mcnt;
        bit ok;
        load_board(64'h0000_0000_FFFF_0222, 16'd0);
        do_move(DIR_LEFT, pre, mcnt, ok);
        checks++; if (pre !== 64'h0000_0000_FFFF_0023) begin failures++; $display("FAIL nodouble_board got=%h exp=%h", pre, 64'h0000_0000_FFFF_0023); end
        checks++; if (score !== 16'd8) begin failures++; $display("FAIL nodouble_score got=%0d exp=8", score); end
        checks++; if (win !== 1'b1) begin failures++; $display("FAIL win_flag got=%b exp=1", win); end
    endtask

    task automatic test_directions;
        logic [BW-1:0] pre;
        int mcnt;
        bit ok;
        load_board(64'h0000_0000_0000_2101, 16'd0);
        do_move(DIR_RIGHT, pre, mcnt, ok);
        checks++; if (pre !== 64'h0000_0000_0000_2200) begin failures++; $display("FAIL right_board got=%h exp=%h", pre, 64'h0000_0000_0000_2200); end
        checks++; if (score !== 16'd4) begin failures++; $display("FAIL right_score got=%0d exp=4", score); end
        load_board(64'h0000_0000_0001_0001, 16'd0);
        do_move(DIR_DOWN, pre, mcnt, ok);
        checks++; if (pre !== 64'h0002_0000_0000_0000) begin failures++; $display("FAIL down_board got=%h exp=%h", pre, 64'h0002_0000_0000_0000); end
        load_board(64'h0000_0000_0001_0001, 16'd0);
        do_move(DIR_UP, pre, mcnt, ok);
        checks++; if (pre !== 64'h0000_0000_0000_0002) begin failures++; $display("FAIL up_board got=%h exp=%h", pre, 64'h0000_0000_0000_0002); end
        checks++; if (score !== 16'd4) begin failures++; $display("FAIL up_score got=%0d exp=4", score); end
    endtask

    task automatic test_no_move;
        logic [BW-1:0] pre;
        int mcnt;
        bit ok;
        load_board(64'h0000_0000_0021_4321, 16'd100);
        do_move(DIR_LEFT, pre, mcnt, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL nomove_idle got=%b exp=1", ok); end
        checks++; if (mcnt != 0) begin failures++; $display("FAIL nomove_moved got=%0d exp=0", mcnt); end
        checks++; if (tiles !== 64'h0000_0000_0021_4321) begin failures++; $display("FAIL nomove_board got=%h exp=%h", tiles, 64'h0000_0000_0021_4321); end
        checks++; if (score !== 16'd100) begin failures++; $display("FAIL nomove_score got=%0d exp=100", score); end
    endtask

    task automatic test_game_over;
        logic [BW-1:0] pre, fin;
        int mcnt;
        bit ok;
        load_board(64'h5454_4545_7654_2245, 16'd0);
        do_move(DIR_LEFT, pre, mcnt, ok);
        checks++; if (pre !== 64'h5454_4545_7654_0345) begin failures++; $display("FAIL over_preboard got=%h exp=%h", pre, 64'h5454_4545_7654_0345); end
        checks++; if ({tiles[63:16], tiles[11:0]} !== {48'h5454_4545_7654, 12'h345}) begin failures++; $display("FAIL over_board got=%h exp=5454454576540345_plus_spawn", tiles); end
        checks++; if (tiles[15:12] != 4'd1 && tiles[15:12] != 4'd2) begin failures++; $display("FAIL over_spawn got=%0d exp=1_or_2", tiles[15:12]); end
        checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL over_flag got=%b exp=1", game_over); end
        checks++; if (mv.dir_ready !== 1'b0) begin failures++; $display("FAIL over_ready got=%b exp=0", mv.dir_ready); end
        fin = tiles;
        mv.dir       = DIR_RIGHT;
        mv.dir_valid = 1'b1;
        repeat (8) @(negedge clk);
        mv.dir_valid = 1'b0;
        @(negedge clk);
        checks++; if (tiles !== fin) begin failures++; $display("FAIL over_hold got=%h exp=%h", tiles, fin); end
        checks++; if ({game_over, mv.dir_ready} !== 2'b10) begin failures++; $display("FAIL over_stays got=%b exp=10", {game_over, mv.dir_ready}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tiles !== '0 || score !== '0) begin failures++; $display("FAIL async_reset got=%h/%0d exp=0/0", tiles, score); end
        checks++; if ({win, game_over, mv.dir_ready} !== 3'b000) begin failures++; $display("FAIL async_reset_flags got=%b exp=000", {win, game_over, mv.dir_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL reinit_ready got=%b exp=1", ok); end
    endtask

    task automatic test_undo;
        logic [BW-1:0] pre, fin;
        int mcnt;
        bit ok;
        load_board(64'h0000_0000_0000_0011, 16'd20);
        do_move(DIR_LEFT, pre, mcnt, ok);
        checks++; if (score !== 16'd24) begin failures++; $display("FAIL undo_move_score got=%0d exp=24", score); end
        fin = tiles;
        mv.undo = 1'b1;
        @(negedge clk);
        mv.undo = 1'b0;
        @(negedge clk);
`ifdef TGE_UNDO_EN
        checks++; if (tiles !== 64'h0000_0000_0000_0011) begin failures++; $display("FAIL undo_board got=%h exp=%h", tiles, 64'h0000_0000_0000_0011); end
        checks++; if (score !== 16'd20) begin failures++; $display("FAIL undo_score got=%0d exp=20", score); end
        mv.undo = 1'b1;
        @(negedge clk);
        mv.undo = 1'b0;
        @(negedge clk);
        checks++; if (tiles !== 64'h0000_0000_0000_0011 || score !== 16'd20) begin failures++; $display("FAIL undo_second got=%h/%0d exp=11/20", tiles, score); end
`else
        checks++; if (tiles !== fin) begin failures++; $display("FAIL undo_ignored_board got=%h exp=%h", tiles, fin); end
        checks++; if (score !== 16'd24) begin failures++; $display("FAIL undo_ignored_score got=%0d exp=24", score); end
`endif
    endtask

    initial begin
        mv.dir_valid = 1'b0;
        mv.undo      = 1'b0;
        mv.dir       = DIR_UP;
        @(negedge clk);
        test_reset();
        test_merge_row();
        test_no_double_merge();
        test_directions();
        test_no_move();
        test_game_over();
        test_undo();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
